// File: rtl/adc_acq_controller.sv
`default_nettype none
// ============================================================================
// Module      : adc_acq_controller
// Description : Acquisition sequencer for the ADC chain in the data_clk
//               domain. Arms on acq_enable, starts immediately or on a
//               trigger (soft_trig / ext_trig rising edge), issues one
//               registered capture_en per accepted new_sample, frames the
//               samples into packets (sample_tlast), timestamps the trigger
//               and flags samples dropped under back-pressure (overflow).
// Ports       : data_clk, reset_n (async active-low)
//               new_sample, acq_enable, trig_mode, soft_trig, ext_trig,
//               post_samples[CNT_W], frame_len[FRAME_W], stream_ready  (in)
//               capture_en, sample_tlast, sample_count[CNT_W],
//               trig_timestamp[CNT_W], acq_state[2], acq_done,
//               overflow                                               (out)
// Revision    : 1.0 - initial release
// ============================================================================
module adc_acq_controller #(
    parameter int CNT_W   = 32,
    parameter int FRAME_W = 16
) (
    input  logic               data_clk,
    input  logic               reset_n,
    input  logic               new_sample,
    input  logic               acq_enable,
    input  logic               trig_mode,
    input  logic               soft_trig,
    input  logic               ext_trig,
    input  logic [CNT_W-1:0]   post_samples,
    input  logic [FRAME_W-1:0] frame_len,
    input  logic               stream_ready,
    output logic               capture_en,
    output logic               sample_tlast,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   trig_timestamp,
    output logic [1:0]         acq_state,
    output logic               acq_done,
    output logic               overflow
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [CNT_W-1:0]   tick_cnt;
    logic               ext_trig_d;
    logic [CNT_W-1:0]   post_lat;
    logic [FRAME_W-1:0] frame_lat;
    logic [FRAME_W-1:0] frame_cnt;

    logic               ext_rise;
    logic [CNT_W-1:0]   count_inc;
    logic [FRAME_W-1:0] frame_last_idx;
    logic               arm_fire;
    logic               trig_fire;
    logic               accept;
    logic               drop;
    logic               final_sample;
    logic               tlast_next;

    assign ext_rise       = ext_trig & ~ext_trig_d;
    assign count_inc      = sample_count + CNT_ONE;
    // A frame length of zero behaves as one sample per packet.
    assign frame_last_idx = (frame_lat == '0) ? '0 : (frame_lat - FRAME_ONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and per-cycle event decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        arm_fire     = 1'b0;
        trig_fire    = 1'b0;
        accept       = 1'b0;
        drop         = 1'b0;
        final_sample = 1'b0;
        tlast_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (acq_enable) begin
                    state_next = S_ARMED;
                    arm_fire   = 1'b1;
                end
            end
            S_ARMED: begin
                if (!acq_enable) begin
                    state_next = S_IDLE;
                end else if (!trig_mode || soft_trig || ext_rise) begin
                    state_next = S_RUN;
                    trig_fire  = 1'b1;
                end
            end
            S_RUN: begin
                // Abort wins over a coincident new_sample: nothing captured.
                if (!acq_enable) begin
                    state_next = S_IDLE;
                end else if (new_sample) begin
                    if (stream_ready) begin
                        accept       = 1'b1;
                        final_sample = (post_lat != '0) && (count_inc == post_lat);
                        tlast_next   = final_sample || (frame_cnt == frame_last_idx);
                        if (final_sample) begin
                            state_next = S_DONE;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!acq_enable) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: tick counter, trigger edge, latched config, counters
    // ------------------------------------------------------------------
    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt       <= '0;
            ext_trig_d     <= 1'b0;
            post_lat       <= '0;
            frame_lat      <= '0;
            frame_cnt      <= '0;
            sample_count   <= '0;
            trig_timestamp <= '0;
            capture_en     <= 1'b0;
            sample_tlast   <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            ext_trig_d   <= ext_trig;
            capture_en   <= accept;
            sample_tlast <= tlast_next;

            if (new_sample) begin
                tick_cnt <= tick_cnt + CNT_ONE;
            end

            if (arm_fire) begin
                post_lat     <= post_samples;
                frame_lat    <= frame_len;
                frame_cnt    <= '0;
                sample_count <= '0;
                overflow     <= 1'b0;
            end

            // Timestamp is the tick value before any coincident increment.
            if (trig_fire) begin
                trig_timestamp <= tick_cnt;
            end

            if (accept) begin
                sample_count <= count_inc;
                frame_cnt    <= tlast_next ? '0 : (frame_cnt + FRAME_ONE);
            end

            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign acq_state = state;
    assign acq_done  = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_adc_acq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_acq_controller
// Description : Directed self-checking bench for adc_acq_controller
//               (CNT_W=4 so that counter wrap is reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_acq_controller;

    localparam int CNT_W   = 4;
    localparam int FRAME_W = 8;

    logic               data_clk;
    logic               reset_n;
    logic               new_sample;
    logic               acq_enable;
    logic               trig_mode;
    logic               soft_trig;
    logic               ext_trig;
    logic [CNT_W-1:0]   post_samples;
    logic [FRAME_W-1:0] frame_len;
    logic               stream_ready;
    logic               capture_en;
    logic               sample_tlast;
    logic [CNT_W-1:0]   sample_count;
    logic [CNT_W-1:0]   trig_timestamp;
    logic [1:0]         acq_state;
    logic               acq_done;
    logic               overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic             s_pre;
    logic             s_cap;
    logic             s_last;
    logic [CNT_W-1:0] s_cnt;
    logic [1:0]       s_st;
    logic             s_ovf;

    adc_acq_controller #(
        .CNT_W   (CNT_W),
        .FRAME_W (FRAME_W)
    ) dut (
        .data_clk       (data_clk),
        .reset_n        (reset_n),
        .new_sample     (new_sample),
        .acq_enable     (acq_enable),
        .trig_mode      (trig_mode),
        .soft_trig      (soft_trig),
        .ext_trig       (ext_trig),
        .post_samples   (post_samples),
        .frame_len      (frame_len),
        .stream_ready   (stream_ready),
        .capture_en     (capture_en),
        .sample_tlast   (sample_tlast),
        .sample_count   (sample_count),
        .trig_timestamp (trig_timestamp),
        .acq_state      (acq_state),
        .acq_done       (acq_done),
        .overflow       (overflow)
    );

    initial data_clk = 1'b0;
    always #5 data_clk = ~data_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge data_clk);
        reset_n      = 1'b0;
        new_sample   = 1'b0;
        acq_enable   = 1'b0;
        trig_mode    = 1'b0;
        soft_trig    = 1'b0;
        ext_trig     = 1'b0;
        post_samples = '0;
        frame_len    = '0;
        stream_ready = 1'b1;
        repeat (2) @(negedge data_clk);
        reset_n = 1'b1;
        @(negedge data_clk);
    endtask

    // One new_sample strobe; returns outputs seen the cycle after it.
    task automatic do_sample(input logic ready, input logic en,
                             output logic pre, output logic cap, output logic last,
                             output logic [CNT_W-1:0] cnt, output logic [1:0] st,
                             output logic ovf);
        @(negedge data_clk);
        new_sample   = 1'b1;
        stream_ready = ready;
        acq_enable   = en;
        pre          = capture_en;
        @(negedge data_clk);
        new_sample = 1'b0;
        cap  = capture_en;
        last = sample_tlast;
        cnt  = sample_count;
        st   = acq_state;
        ovf  = overflow;
        repeat (3) @(negedge data_clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({capture_en, sample_tlast, sample_count, trig_timestamp, acq_state, acq_done, overflow} !== '0)
            $display("FAIL reset_outputs: got cap=%0b last=%0b cnt=%0d ts=%0d st=%0d done=%0b ovf=%0b expected all 0",
                     capture_en, sample_tlast, sample_count, trig_timestamp, acq_state, acq_done, overflow);
        else n_pass++;
    endtask

    task automatic test_immediate();
        logic exp_last;
        do_reset();
        trig_mode = 1'b0; post_samples = 4'd5; frame_len = 8'd2; stream_ready = 1'b1;
        acq_enable = 1'b1;
        @(negedge data_clk);
        n_checks++;
        if (acq_state !== 2'd1) $display("FAIL imm_armed: got %0d expected 1", acq_state);
        else n_pass++;
        @(negedge data_clk);
        n_checks++;
        if (acq_state !== 2'd2) $display("FAIL imm_run: got %0d expected 2", acq_state);
        else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            exp_last = (i == 2) || (i == 4) || (i == 5);
            do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
            n_checks++;
            if ({s_pre, s_cap, s_last, s_cnt} !== {1'b0, 1'b1, exp_last, 4'(i)})
                $display("FAIL imm_capture_%0d: got pre=%0b cap=%0b last=%0b cnt=%0d expected pre=0 cap=1 last=%0b cnt=%0d",
                         i, s_pre, s_cap, s_last, s_cnt, exp_last, i);
            else n_pass++;
        end
        n_checks++;
        if ({s_st, acq_done, sample_count} !== {2'd3, 1'b1, 4'd5})
            $display("FAIL imm_done: got st=%0d done=%0b cnt=%0d expected st=3 done=1 cnt=5", s_st, acq_done, sample_count);
        else n_pass++;
        do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
        n_checks++;
        if ({s_cap, s_cnt, s_st} !== {1'b0, 4'd5, 2'd3})
            $display("FAIL imm_hold_done: got cap=%0b cnt=%0d st=%0d expected cap=0 cnt=5 st=3", s_cap, s_cnt, s_st);
        else n_pass++;
        acq_enable = 1'b0;
        @(negedge data_clk);
        n_checks++;
        if ({acq_state, acq_done} !== {2'd0, 1'b0})
            $display("FAIL imm_to_idle: got st=%0d done=%0b expected st=0 done=0", acq_state, acq_done);
        else n_pass++;
    endtask

    task automatic test_ext_trigger();
        logic any_cap;
        do_reset();
        trig_mode = 1'b1; post_samples = 4'd3; frame_len = 8'd1; stream_ready = 1'b1;
        acq_enable = 1'b1;
        @(negedge data_clk);
        any_cap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
            any_cap = any_cap | s_cap | s_pre;
        end
        n_checks++;
        if ({any_cap, acq_state} !== {1'b0, 2'd1})
            $display("FAIL ext_wait_armed: got cap_seen=%0b st=%0d expected cap_seen=0 st=1", any_cap, acq_state);
        else n_pass++;
        // Trigger edge coincident with a new_sample.
        @(negedge data_clk);
        ext_trig   = 1'b1;
        new_sample = 1'b1;
        @(negedge data_clk);
        new_sample = 1'b0;
        n_checks++;
        if ({acq_state, trig_timestamp, capture_en} !== {2'd2, 4'd7, 1'b0})
            $display("FAIL ext_trig_run: got st=%0d ts=%0d cap=%0b expected st=2 ts=7 cap=0", acq_state, trig_timestamp, capture_en);
        else n_pass++;
        @(negedge data_clk);
        n_checks++;
        if ({capture_en, sample_count} !== {1'b0, 4'd0})
            $display("FAIL ext_no_coincident_cap: got cap=%0b cnt=%0d expected cap=0 cnt=0", capture_en, sample_count);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
            n_checks++;
            if ({s_cap, s_last, s_cnt, s_st} !== {1'b1, 1'b1, 4'(i), (i == 3) ? 2'd3 : 2'd2})
                $display("FAIL ext_capture_%0d: got cap=%0b last=%0b cnt=%0d st=%0d expected cap=1 last=1 cnt=%0d st=%0d",
                         i, s_cap, s_last, s_cnt, s_st, i, (i == 3) ? 3 : 2);
            else n_pass++;
        end
        soft_trig = 1'b1;
        @(negedge data_clk);
        soft_trig = 1'b0;
        @(negedge data_clk);
        n_checks++;
        if ({acq_state, trig_timestamp} !== {2'd3, 4'd7})
            $display("FAIL ext_done_ignores_trig: got st=%0d ts=%0d expected st=3 ts=7", acq_state, trig_timestamp);
        else n_pass++;
        ext_trig = 1'b0;
        acq_enable = 1'b0;
        @(negedge data_clk);
    endtask

    task automatic test_soft_trigger();
        do_reset();
        trig_mode = 1'b1; post_samples = 4'd2; frame_len = 8'd1;
        soft_trig = 1'b1;
        ext_trig  = 1'b1;
        @(negedge data_clk);
        soft_trig = 1'b0;
        @(negedge data_clk);
        n_checks++;
        if (acq_state !== 2'd0) $display("FAIL soft_idle_ignored: got %0d expected 0", acq_state);
        else n_pass++;
        // ext_trig is already high before arming, so a steady level must not trigger.
        acq_enable = 1'b1;
        repeat (3) @(negedge data_clk);
        n_checks++;
        if (acq_state !== 2'd1) $display("FAIL level_no_trigger: got %0d expected 1", acq_state);
        else n_pass++;
        ext_trig = 1'b0;
        do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
        do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
        soft_trig = 1'b1;
        @(negedge data_clk);
        soft_trig = 1'b0;
        n_checks++;
        if ({acq_state, trig_timestamp} !== {2'd2, 4'd2})
            $display("FAIL soft_trig_run: got st=%0d ts=%0d expected st=2 ts=2", acq_state, trig_timestamp);
        else n_pass++;
        acq_enable = 1'b0;
        @(negedge data_clk);
    endtask

    task automatic test_back_pressure();
        logic [CNT_W-1:0] exp_cnt;
        logic exp_last;
        logic exp_ovf;
        do_reset();
        trig_mode = 1'b0; post_samples = 4'd10; frame_len = 8'd4;
        acq_enable = 1'b1;
        repeat (2) @(negedge data_clk);
        // Config changed after arming must not matter.
        post_samples = 4'd3;
        frame_len    = 8'd1;
        exp_cnt = '0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 13; i++) begin
            logic rdy;
            rdy = !(i >= 3 && i <= 5);
            do_sample(rdy, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
            if (rdy) exp_cnt = exp_cnt + 4'd1;
            else exp_ovf = 1'b1;
            exp_last = rdy && (exp_cnt == 4'd4 || exp_cnt == 4'd8 || exp_cnt == 4'd10);
            n_checks++;
            if ({s_cap, s_last, s_cnt, s_ovf} !== {rdy, exp_last, exp_cnt, exp_ovf})
                $display("FAIL bp_sample_%0d: got cap=%0b last=%0b cnt=%0d ovf=%0b expected cap=%0b last=%0b cnt=%0d ovf=%0b",
                         i, s_cap, s_last, s_cnt, s_ovf, rdy, exp_last, exp_cnt, exp_ovf);
            else n_pass++;
        end
        n_checks++;
        if ({acq_state, acq_done, sample_count, overflow} !== {2'd3, 1'b1, 4'd10, 1'b1})
            $display("FAIL bp_done: got st=%0d done=%0b cnt=%0d ovf=%0b expected st=3 done=1 cnt=10 ovf=1",
                     acq_state, acq_done, sample_count, overflow);
        else n_pass++;
        acq_enable = 1'b0;
        @(negedge data_clk);
    endtask

    task automatic test_abort();
        do_reset();
        trig_mode = 1'b0; post_samples = 4'd5; frame_len = 8'd0;
        acq_enable = 1'b1;
        repeat (2) @(negedge data_clk);
        do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
        do_sample(1'b0, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
        do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
        n_checks++;
        if ({s_cnt, s_ovf} !== {4'd2, 1'b1})
            $display("FAIL abort_pre: got cnt=%0d ovf=%0b expected cnt=2 ovf=1", s_cnt, s_ovf);
        else n_pass++;
        do_sample(1'b1, 1'b0, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
        n_checks++;
        if ({s_cap, s_last, s_st, s_cnt, s_ovf} !== {1'b0, 1'b0, 2'd0, 4'd2, 1'b1})
            $display("FAIL abort_cycle: got cap=%0b last=%0b st=%0d cnt=%0d ovf=%0b expected cap=0 last=0 st=0 cnt=2 ovf=1",
                     s_cap, s_last, s_st, s_cnt, s_ovf);
        else n_pass++;
        acq_enable = 1'b1;
        @(negedge data_clk);
        n_checks++;
        if ({acq_state, sample_count, overflow} !== {2'd1, 4'd0, 1'b0})
            $display("FAIL rearm_clears: got st=%0d cnt=%0d ovf=%0b expected st=1 cnt=0 ovf=0", acq_state, sample_count, overflow);
        else n_pass++;
        acq_enable = 1'b0;
        @(negedge data_clk);
    endtask

    task automatic test_continuous();
        do_reset();
        trig_mode = 1'b0; post_samples = 4'd0; frame_len = 8'd0;
        acq_enable = 1'b1;
        repeat (2) @(negedge data_clk);
        for (int i = 1; i <= 18; i++) begin
            do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
            n_checks++;
            if ({s_cap, s_last, s_cnt, s_st} !== {1'b1, 1'b1, 4'(i % 16), 2'd2})
                $display("FAIL cont_capture_%0d: got cap=%0b last=%0b cnt=%0d st=%0d expected cap=1 last=1 cnt=%0d st=2",
                         i, s_cap, s_last, s_cnt, s_st, i % 16);
            else n_pass++;
        end
        n_checks++;
        if ({acq_state, acq_done} !== {2'd2, 1'b0})
            $display("FAIL cont_stays_run: got st=%0d done=%0b expected st=2 done=0", acq_state, acq_done);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        // Runs straight after the continuous test, still in RUN with count 2.
        do_sample(1'b1, 1'b1, s_pre, s_cap, s_last, s_cnt, s_st, s_ovf);
        @(negedge data_clk);
        new_sample = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({capture_en, sample_tlast, sample_count, trig_timestamp, acq_state, acq_done, overflow} !== '0)
            $display("FAIL async_reset: got cap=%0b last=%0b cnt=%0d ts=%0d st=%0d done=%0b ovf=%0b expected all 0",
                     capture_en, sample_tlast, sample_count, trig_timestamp, acq_state, acq_done, overflow);
        else n_pass++;
        new_sample = 1'b0;
        acq_enable = 1'b0;
        @(negedge data_clk);
        reset_n = 1'b1;
        @(negedge data_clk);
    endtask

    initial begin
        reset_n      = 1'b0;
        new_sample   = 1'b0;
        acq_enable   = 1'b0;
        trig_mode    = 1'b0;
        soft_trig    = 1'b0;
        ext_trig     = 1'b0;
        post_samples = '0;
        frame_len    = '0;
        stream_ready = 1'b1;
        test_reset();
        test_immediate();
        test_ext_trigger();
        test_soft_trigger();
        test_back_pressure();
        test_abort();
        test_continuous();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
